// File: rtl/axi_rsp_pkg.sv
// axi_rsp_pkg: response codes, burst/size codes, FSM encodings, LFSR seed and burst legality check
package axi_rsp_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] W_INIT = 2'd0;
  localparam logic [1:0] W_IDLE = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;
  localparam logic [1:0] R_INIT = 2'd0;
  localparam logic [1:0] R_IDLE = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // lo/hi are the window bounds [lo, hi); an aligned-down start plus 4*len must stay below hi,
  // which with hi word-aligned is the same as testing the unaligned address
  function automatic logic burst_err(input logic [31:0] addr, input logic [3:0] len,
                                     input logic [2:0] size, input logic [1:0] burst,
                                     input logic [32:0] lo, input logic [32:0] hi);
    return burst != BURST_INCR || size != SIZE_4B || {1'b0, addr} < lo ||
           {1'b0, addr} + {27'd0, len, 2'b00} >= hi;
  endfunction
endpackage

// File: rtl/axi_rsp_mem.sv
// axi_rsp_mem: 2^DEPTH_LOG2 x 32-bit word memory, byte-enabled write port, asynchronous read port
//   clk; we/waddr/wstrb/wdata: write port; raddr/rdata: combinational read port (old data on collision)
module axi_rsp_mem #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [3:0]            wstrb,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[raddr];
endmodule

// File: rtl/axi3_burst_responder.sv
// axi3_burst_responder: AXI3 slave answering INCR bursts from an internal word memory, SLVERR otherwise
//   AXI_clk, rst (async, active-low); AW/W/B write channels; AR/R read channels.
//   AXI_RSP_STALL_EN: LFSR-driven ready bubbles and deferred valid assertion.
module axi3_burst_responder
  import axi_rsp_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h1000_0000,
  parameter int          DEPTH_LOG2 = 10
) (
  input  logic        AXI_clk,
  input  logic        rst,
  input  logic [31:0] AXI_awaddr,
  input  logic [5:0]  AXI_awid,
  input  logic [3:0]  AXI_awlen,
  input  logic [2:0]  AXI_awsize,
  input  logic [1:0]  AXI_awburst,
  input  logic        AXI_awvalid,
  output logic        AXI_awready,
  input  logic [31:0] AXI_wdata,
  input  logic [5:0]  AXI_wid,
  input  logic [3:0]  AXI_wstrb,
  input  logic        AXI_wlast,
  input  logic        AXI_wvalid,
  output logic        AXI_wready,
  output logic [5:0]  AXI_bid,
  output logic [1:0]  AXI_bresp,
  output logic        AXI_bvalid,
  input  logic        AXI_bready,
  input  logic [31:0] AXI_araddr,
  input  logic [5:0]  AXI_arid,
  input  logic [3:0]  AXI_arlen,
  input  logic [2:0]  AXI_arsize,
  input  logic [1:0]  AXI_arburst,
  input  logic        AXI_arvalid,
  output logic        AXI_arready,
  output logic [31:0] AXI_rdata,
  output logic [5:0]  AXI_rid,
  output logic [1:0]  AXI_rresp,
  output logic        AXI_rlast,
  output logic        AXI_rvalid,
  input  logic        AXI_rready
);
  localparam logic [32:0] WIN_LO = {1'b0, BASE};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << DEPTH_LOG2);
  logic [1:0] ws, rs;
  logic [5:0] wid_q, rid_q;
  logic [DEPTH_LOG2-1:0] widx, ridx, mem_raddr;
  logic [3:0] wlen, wbeat, rlen, rbeat;
  logic werr, wbad, rerr, b_arm, r_arm, st_rdy, st_vld, mem_we, aw_err, ar_err;
  logic [31:0] mem_rdata, rdata_q;
`ifdef AXI_RSP_STALL_EN
  logic [7:0] lfsr;
  always_ff @(posedge AXI_clk or negedge rst)
    if (!rst) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign st_rdy = lfsr[0];
  assign st_vld = lfsr[1];
`else
  assign st_rdy = 1'b0;
  assign st_vld = 1'b0;
`endif
  assign aw_err = burst_err(AXI_awaddr, AXI_awlen, AXI_awsize, AXI_awburst, WIN_LO, WIN_HI);
  assign ar_err = burst_err(AXI_araddr, AXI_arlen, AXI_arsize, AXI_arburst, WIN_LO, WIN_HI);
  assign AXI_awready = ws == W_IDLE && !st_rdy;
  assign AXI_wready  = ws == W_DATA && !st_rdy;
  // b_arm/r_arm remember that valid was already shown, so a stall bit cannot withdraw it
  assign AXI_bvalid  = ws == W_RESP && (b_arm || !st_vld);
  assign AXI_bid     = wid_q;
  assign AXI_bresp   = wbad ? RESP_SLVERR : RESP_OKAY;
  assign AXI_arready = rs == R_IDLE && !st_rdy;
  assign AXI_rvalid  = rs == R_DATA && (r_arm || !st_vld);
  assign AXI_rlast   = rs == R_DATA && rbeat == rlen;
  assign AXI_rid     = rid_q;
  assign AXI_rresp   = rerr ? RESP_SLVERR : RESP_OKAY;
  assign AXI_rdata   = rdata_q;
  assign mem_we      = AXI_wvalid && AXI_wready && !werr;
  // BASE is window-aligned, so the word index is just the low address bits
  assign mem_raddr   = rs == R_DATA ? ridx + DEPTH_LOG2'(1) : AXI_araddr[DEPTH_LOG2+1:2];
  axi_rsp_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk(AXI_clk), .we(mem_we), .waddr(widx), .wstrb(AXI_wstrb), .wdata(AXI_wdata),
    .raddr(mem_raddr), .rdata(mem_rdata)
  );
  always_ff @(posedge AXI_clk or negedge rst)
    if (!rst) begin
      ws <= W_INIT;
      wid_q <= '0;
      widx <= '0;
      wlen <= '0;
      wbeat <= '0;
      werr <= 1'b0;
      wbad <= 1'b0;
      b_arm <= 1'b0;
    end else begin
      b_arm <= ws == W_RESP && !(AXI_bvalid && AXI_bready);
      case (ws)
        W_INIT: ws <= W_IDLE;
        W_IDLE: if (AXI_awvalid && AXI_awready) begin
          ws <= W_DATA;
          wid_q <= AXI_awid;
          widx <= AXI_awaddr[DEPTH_LOG2+1:2];
          wlen <= AXI_awlen;
          wbeat <= '0;
          werr <= aw_err;
          wbad <= aw_err;
        end
        W_DATA: if (AXI_wvalid && AXI_wready) begin
          widx <= widx + DEPTH_LOG2'(1);
          wbeat <= wbeat + 4'd1;
          if (AXI_wlast != (wbeat == wlen) || AXI_wid != wid_q) wbad <= 1'b1;
          if (wbeat == wlen) ws <= W_RESP;
        end
        W_RESP: if (AXI_bvalid && AXI_bready) ws <= W_IDLE;
        default: ws <= W_INIT;
      endcase
    end
  always_ff @(posedge AXI_clk or negedge rst)
    if (!rst) begin
      rs <= R_INIT;
      rid_q <= '0;
      ridx <= '0;
      rlen <= '0;
      rbeat <= '0;
      rerr <= 1'b0;
      rdata_q <= '0;
      r_arm <= 1'b0;
    end else begin
      r_arm <= rs == R_DATA && !(AXI_rvalid && AXI_rready);
      case (rs)
        R_INIT: rs <= R_IDLE;
        R_IDLE: if (AXI_arvalid && AXI_arready) begin
          rs <= R_DATA;
          rid_q <= AXI_arid;
          ridx <= AXI_araddr[DEPTH_LOG2+1:2];
          rlen <= AXI_arlen;
          rbeat <= '0;
          rerr <= ar_err;
          rdata_q <= ar_err ? '0 : mem_rdata;
        end
        R_DATA: if (AXI_rvalid && AXI_rready) begin
          if (AXI_rlast) rs <= R_IDLE;
          else begin
            ridx <= ridx + DEPTH_LOG2'(1);
            rbeat <= rbeat + 4'd1;
            rdata_q <= rerr ? '0 : mem_rdata;
          end
        end
        default: rs <= R_INIT;
      endcase
    end
endmodule

// File: tb/tb_axi3_burst_responder.sv
// tb_axi3_burst_responder: randomized bursts against a word-array reference model of the responder
module tb_axi3_burst_responder;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int DEPTH = 1024;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
  logic [5:0] awid = 0, wid = 0, arid = 0;
  logic [3:0] awlen = 0, wstrb = 0, arlen = 0;
  logic [2:0] awsize = 0, arsize = 0;
  logic [1:0] awburst = 0, arburst = 0;
  logic awvalid = 0, wlast = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic [5:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  axi3_burst_responder dut (
    .AXI_clk(clk), .rst(rst),
    .AXI_awaddr(awaddr), .AXI_awid(awid), .AXI_awlen(awlen), .AXI_awsize(awsize),
    .AXI_awburst(awburst), .AXI_awvalid(awvalid), .AXI_awready(awready),
    .AXI_wdata(wdata), .AXI_wid(wid), .AXI_wstrb(wstrb), .AXI_wlast(wlast),
    .AXI_wvalid(wvalid), .AXI_wready(wready),
    .AXI_bid(bid), .AXI_bresp(bresp), .AXI_bvalid(bvalid), .AXI_bready(bready),
    .AXI_araddr(araddr), .AXI_arid(arid), .AXI_arlen(arlen), .AXI_arsize(arsize),
    .AXI_arburst(arburst), .AXI_arvalid(arvalid), .AXI_arready(arready),
    .AXI_rdata(rdata), .AXI_rid(rid), .AXI_rresp(rresp), .AXI_rlast(rlast),
    .AXI_rvalid(rvalid), .AXI_rready(rready)
  );
  int nvec = 0, nerr = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] wd [16];
  logic [3:0] wsb [16];
  typedef struct { logic [31:0] d; logic [1:0] r; logic l; logic [5:0] id; } rx_t;
  typedef struct { logic [1:0] r; logic [5:0] id; } bx_t;
  rx_t rq[$];
  bx_t bq[$];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask

  function automatic bit mdl_err(input logic [31:0] a, input logic [3:0] len, input logic [2:0] sz, input logic [1:0] bu);
    longint s = longint'(a) & ~longint'(3);
    return bu != 2'b01 || sz != 3'b010 || s < longint'(BASE) ||
           s + 4 * longint'(len) > longint'(BASE) + 4 * DEPTH - 4;
  endfunction

  always @(negedge clk) if (rst) begin
    if (rvalid) begin
      if (rq.size() == 0) chk("r_spurious", 32'(rvalid), 0);
      else begin
        chk("rdata", rdata, rq[0].d);
        chk("rresp", 32'(rresp), 32'(rq[0].r));
        chk("rlast", 32'(rlast), 32'(rq[0].l));
        chk("rid", 32'(rid), 32'(rq[0].id));
        if (rready) void'(rq.pop_front());
      end
    end
    if (bvalid) begin
      if (bq.size() == 0) chk("b_spurious", 32'(bvalid), 0);
      else begin
        chk("bresp", 32'(bresp), 32'(bq[0].r));
        chk("bid", 32'(bid), 32'(bq[0].id));
        if (bready) void'(bq.pop_front());
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [3:0] len, input logic [2:0] sz, input logic [1:0] bu,
                          input logic [5:0] id, input int badlast, input bit badid, input int gaps);
    bit e;
    int t, idx;
    e = mdl_err(a, len, sz, bu);
    idx = int'((a - BASE) >> 2);
    bq.push_back('{r: (e || badlast >= 0 || badid) ? 2'b10 : 2'b00, id: id});
    awaddr = a; awlen = len; awsize = sz; awburst = bu; awid = id; awvalid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready && t < 100);
    if (!awready) chk("aw_timeout", 0, 1);
    @(posedge clk); #1 awvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      if (b > 0) repeat ($urandom_range(0, gaps)) begin @(posedge clk); #1; end
      wdata = wd[b]; wstrb = wsb[b]; wid = badid ? id ^ 6'h1 : id; wvalid = 1;
      wlast = badlast >= 0 ? b == badlast : b == int'(len);
      t = 0;
      do begin @(negedge clk); t++; end while (!wready && t < 100);
      if (!wready) chk("w_timeout", 0, 1);
`ifndef AXI_RSP_STALL_EN
      if (b == 0) chk("wready_lat", t, 1);
`endif
      if (!e) for (int i = 0; i < 4; i++) if (wsb[b][i]) mdl[idx + b][8*i +: 8] = wd[b][8*i +: 8];
      @(posedge clk); #1 wvalid = 0; wlast = 0;
    end
    @(negedge clk);
`ifndef AXI_RSP_STALL_EN
    chk("bvalid_lat", 32'(bvalid), 1);
`endif
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(posedge clk); #1 bready = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bvalid && t < 100);
    if (!bvalid) chk("b_timeout", 0, 1);
    @(posedge clk); #1 bready = 0;
  endtask

  // mode: 0 rready held high, 1 toggling, 2 random; abort >= 0 pulls reset at that beat
  task automatic do_read(input logic [31:0] a, input logic [3:0] len, input logic [2:0] sz, input logic [1:0] bu,
                         input logic [5:0] id, input int mode, input int abort);
    bit e;
    int t, idx, n;
    e = mdl_err(a, len, sz, bu);
    idx = int'((a - BASE) >> 2);
    araddr = a; arlen = len; arsize = sz; arburst = bu; arid = id; arvalid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!arready && t < 100);
    if (!arready) chk("ar_timeout", 0, 1);
    for (int b = 0; b <= int'(len); b++)
      rq.push_back('{d: e ? 32'd0 : mdl[idx + b], r: e ? 2'b10 : 2'b00, l: b == int'(len), id: id});
    @(posedge clk); #1 arvalid = 0; rready = mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
    n = 0; t = 0;
    while (rq.size() > 0 && t < 200) begin
      @(negedge clk); t++;
`ifndef AXI_RSP_STALL_EN
      if (t == 1) chk("rvalid_lat", 32'(rvalid), 1);
`endif
      if (abort >= 0 && n == abort) begin
        #2 rst = 0;
        #1 chk("abort_rvalid", 32'(rvalid), 0);
        chk("abort_rlast", 32'(rlast), 0);
        chk("abort_rdata", rdata, 0);
        chk("abort_rid", 32'(rid), 0);
        chk("abort_arready", 32'(arready), 0);
        rq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1; rready = 0;
        return;
      end
      if (rvalid && rready) n++;
      @(posedge clk); #1 rready = mode == 0 ? 1'b1 : mode == 1 ? ~rready : 1'($urandom_range(0, 1));
    end
    if (rq.size() > 0) chk("r_timeout", 32'(rq.size()), 0);
`ifndef AXI_RSP_STALL_EN
    else if (mode == 0) chk("r_backtoback", t, int'(len) + 1);
`endif
    rq.delete();
    rready = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(awready), 0); chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);   chk("rst_bresp", 32'(bresp), 0);
    chk("rst_bid", 32'(bid), 0);         chk("rst_arready", 32'(arready), 0);
    chk("rst_rvalid", 32'(rvalid), 0);   chk("rst_rlast", 32'(rlast), 0);
    chk("rst_rresp", 32'(rresp), 0);     chk("rst_rid", 32'(rid), 0);
    chk("rst_rdata", rdata, 0);
    rst = 1;
    @(posedge clk); #1;
    for (int k = 0; k < DEPTH / 16; k++) begin
      for (int b = 0; b < 16; b++) begin wd[b] = $urandom; wsb[b] = 4'hF; end
      do_write(BASE + 32'(k * 64), 4'd15, 3'b010, 2'b01, 6'(k), -1, 0, 0);
    end
    for (int b = 0; b < 16; b++) begin wd[b] = 32'(b); wsb[b] = 4'hF; end
    do_write(32'h1000_0040, 4'd15, 3'b010, 2'b01, 6'h2A, -1, 0, 0);
    chk("mdl_pin_first", mdl[16], 32'd0);
    chk("mdl_pin_last", mdl[31], 32'd15);
    do_read(32'h1000_0040, 4'd15, 3'b010, 2'b01, 6'h15, 0, -1);
    wd[0] = 32'hFFFF_FFFF; wsb[0] = 4'hF;
    do_write(32'h1000_0100, 4'd0, 3'b010, 2'b01, 6'h01, -1, 0, 0);
    wd[0] = 32'h1122_3344; wsb[0] = 4'b0101;
    do_write(32'h1000_0100, 4'd0, 3'b010, 2'b01, 6'h02, -1, 0, 0);
    chk("mdl_pin_strb", mdl[64], 32'hFF22_FF44);
    do_read(32'h1000_0100, 4'd0, 3'b010, 2'b01, 6'h03, 0, -1);
    chk("mdl_pin_overrun", 32'(mdl_err(32'h1000_0FC4, 4'd15, 3'b010, 2'b01)), 1);
    chk("mdl_pin_edge", 32'(mdl_err(32'h1000_0FC0, 4'd15, 3'b010, 2'b01)), 0);
    chk("mdl_pin_below", 32'(mdl_err(32'h0FFF_FFFC, 4'd0, 3'b010, 2'b01)), 1);
    do_read(32'h1000_0FC4, 4'd15, 3'b010, 2'b01, 6'h07, 0, -1);
    do_read(32'h1000_0FC0, 4'd15, 3'b010, 2'b01, 6'h08, 1, -1);
    do_read(32'h1000_0200, 4'd3, 3'b010, 2'b00, 6'h09, 0, -1);
    do_read(32'h1000_0200, 4'd3, 3'b001, 2'b01, 6'h0A, 0, -1);
    do_read(32'h0FFF_FFF0, 4'd3, 3'b010, 2'b01, 6'h0B, 0, -1);
    for (int b = 0; b < 16; b++) begin wd[b] = $urandom; wsb[b] = 4'hF; end
    do_write(32'h1000_0200, 4'd15, 3'b010, 2'b01, 6'h11, 7, 0, 0);
    do_write(32'h1000_0240, 4'd3, 3'b010, 2'b01, 6'h12, -1, 1, 0);
    do_write(32'h1000_0FF0, 4'd7, 3'b010, 2'b01, 6'h13, -1, 0, 1);
    do_read(32'h1000_0200, 4'd15, 3'b010, 2'b01, 6'h14, 2, -1);
    fork
      do_write(32'h1000_0300, 4'd15, 3'b010, 2'b01, 6'h21, -1, 0, 2);
      do_read(32'h1000_0800, 4'd15, 3'b010, 2'b01, 6'h22, 1, -1);
    join
    do_read(32'h1000_0300, 4'd15, 3'b010, 2'b01, 6'h23, 0, -1);
    do_read(32'h1000_0040, 4'd15, 3'b010, 2'b01, 6'h24, 0, 5);
    do_read(32'h1000_0040, 4'd15, 3'b010, 2'b01, 6'h25, 0, -1);
    for (int it = 0; it < 150; it++) begin
      logic [31:0] wa, ra;
      logic [2:0] wsz, rsz;
      logic [1:0] wbu, rbu;
      wa = BASE + $urandom_range(0, 'h700);
      ra = BASE + 32'h800 + $urandom_range(0, 'h7FF);
      if ($urandom_range(0, 7) == 0) ra = BASE - $urandom_range(1, 64);
      wsz = $urandom_range(0, 9) == 0 ? 3'($urandom_range(0, 7)) : 3'b010;
      rsz = $urandom_range(0, 9) == 0 ? 3'($urandom_range(0, 7)) : 3'b010;
      wbu = $urandom_range(0, 9) == 0 ? 2'($urandom_range(0, 3)) : 2'b01;
      rbu = $urandom_range(0, 9) == 0 ? 2'($urandom_range(0, 3)) : 2'b01;
      for (int b = 0; b < 16; b++) begin wd[b] = $urandom; wsb[b] = 4'($urandom); end
      fork
        do_write(wa, 4'($urandom), wsz, wbu, 6'($urandom), -1, $urandom_range(0, 9) == 0, 2);
        do_read(ra, 4'($urandom), rsz, rbu, 6'($urandom), $urandom_range(0, 2), -1);
      join
      if (it % 10 == 0) do_read(wa, 4'($urandom), 3'b010, 2'b01, 6'($urandom), $urandom_range(0, 2), -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/axi3_burst_responder.md
# axi3_burst_responder

AXI3 slave that answers the 16-beat INCR read and write bursts issued by the stream-to-AXI bridges, backed by an internal word memory. It stands in for the HP-port/DDR side in block-level and system simulations, and serves as an on-fabric scratch buffer when the bridges target it. Write and read channels run independently on one clock. Out-of-window or unsupported bursts are answered with SLVERR.

## Interface
- BASE, 32'h1000_0000, byte address of word 0; must be aligned to 4·2^DEPTH_LOG2.
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KB window).
- AXI_clk  in  1  sole clock; all logic rising-edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion is synchronized externally.
- AXI_awaddr in 32, AXI_awid in 6, AXI_awlen in 4, AXI_awsize in 3, AXI_awburst in 2, AXI_awvalid in 1, AXI_awready out 1: write address channel.
- AXI_wdata in 32, AXI_wid in 6, AXI_wstrb in 4, AXI_wlast in 1, AXI_wvalid in 1, AXI_wready out 1: write data channel.
- AXI_bid out 6, AXI_bresp out 2, AXI_bvalid out 1, AXI_bready in 1: write response channel.
- AXI_araddr in 32, AXI_arid in 6, AXI_arlen in 4, AXI_arsize in 3, AXI_arburst in 2, AXI_arvalid in 1, AXI_arready out 1: read address channel.
- AXI_rdata out 32, AXI_rid out 6, AXI_rresp out 2, AXI_rlast out 1, AXI_rvalid out 1, AXI_rready in 1: read data channel.
- lock/cache/prot/qos are not ports; they are ignored.

## Operation
- Write FSM: W_IDLE (awready=1) → on awvalid: latch id, word index = (awaddr−BASE)>>2, len, err → W_DATA (wready=1) → each wvalid beat writes bytes enabled by wstrb (skipped if err), index+1, beat+1 → after beat == len → W_RESP (bvalid=1, bid=latched id) → on bready → W_IDLE.
- Read FSM: R_IDLE (arready=1) → on arvalid: latch id/index/len/err, load rdata ← mem[index] → R_DATA (rvalid=1, rlast when beat == len) → on rready: advance index, load next word; after last beat → R_IDLE.
- err is set when: awburst/arburst ≠ 2'b01, awsize/arsize ≠ 3'b010, start address < BASE, or start + 4·len ≥ BASE + 4·2^DEPTH_LOG2. Address bits [1:0] are ignored (aligned down).
- Write error response: bresp = 2'b10 if err, if wlast ≠ (beat == len) on any beat, or if wid ≠ latched id; otherwise 2'b00. The burst always consumes exactly len+1 beats.
- Read error response: rresp = 2'b10 and rdata = 0 on every beat; rlast is still produced correctly.
- Same-cycle read and write to one word: the read returns the old data.
- Memory contents are not reset.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, bresp=0, bid=0, arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0. FSMs enter W_IDLE/R_IDLE on the first clock after release.
- AW handshake at cycle N → wready from N+1. The last W beat at cycle M → bvalid at M+1.
- AR handshake at cycle N → first rvalid at N+1. With rready held high, beats are back-to-back: a 16-beat burst completes at N+16.
- Once asserted, a VALID is held with stable payload until its READY. awready and arready are deasserted while the corresponding FSM is busy, so there is one outstanding burst per direction.
- rst asserted mid-burst: both FSMs abort and all outputs take their reset values immediately. A partially written burst leaves earlier beats in memory.

## Configuration
- AXI_RSP_STALL_EN defined: an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5, one step per clock) inserts bubbles.
  - When bit0 = 1, awready, wready and arready are forced low.
  - When bit1 = 1, assertion of bvalid and of each new rvalid is deferred by one cycle.
  - A VALID that is already asserted is never withdrawn.
- AXI_RSP_STALL_EN undefined: no bubbles and the timing stated above is exact.

## Structure
- Package axi_rsp_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10
  - BURST_INCR = 2'b01 and SIZE_4B = 3'b010
  - the write and read FSM state encodings
  - LFSR_SEED
- Sub-module axi_rsp_mem is the dual-port word memory: one write port with 4-bit byte enables and one asynchronous read port, depth 2^DEPTH_LOG2.

## Test plan
- Write a 16-beat INCR burst at 0x1000_0040 with data 0..15 and wstrb = 4'hF → bresp = 00 and bid echoes the id. A read of 0x1000_0040 then returns 0..15, rlast only on beat 15, rvalid 1 cycle after the AR handshake.
- A write with wstrb = 4'b0101 over a word holding 0xFFFF_FFFF, data 0x1122_3344 → the word reads back as 0xFF22_FF44.
- A read at 0x1000_0FC4 with arlen = 15 (overruns the window) → 16 beats, each with rresp = 10 and rdata = 0, rlast on beat 15.
- A write burst with awlen = 15 where wlast is asserted on beat 7 → all 16 beats accepted, bresp = 10.
- A read and a write running concurrently to different addresses, with rready toggling 1/0 → neither channel blocks the other, and rdata is stable while rvalid=1 and rready=0.
- rst driven low at beat 5 of a read → rvalid drops to 0 at once. After release, a new AR is accepted and returns correct data.
